// File: rtl/muldiv_ctrl.sv
// HI/LO sequencing controller for an external multiplier and divider.
// Starts the unit, waits a fixed latency, captures results; handles MTHI/MTLO, abort and divide-by-zero.
module muldiv_ctrl #(
  parameter int unsigned DIV_LAT  = 32,
  parameter int unsigned MULT_LAT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_start,
  output logic        mult_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        div_divzero
);

  localparam int unsigned MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

  localparam logic [2:0] OP_MULT = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_MTHI = 3'b010;
  localparam logic [2:0] OP_MTLO = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN_DIV  = 3'd1,
    S_RUN_MULT = 3'd2,
    S_DONE     = 3'd3,
    S_DZERO    = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      hi_nxt, lo_nxt;
  logic [31:0]      div_a_nxt, div_b_nxt, mult_a_nxt, mult_b_nxt;
  logic             busy_nxt, done_nxt, div_zero_exc_nxt, div_start_nxt, mult_start_nxt;

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      hi           <= '0;
      lo           <= '0;
      div_a        <= '0;
      div_b        <= '0;
      mult_a       <= '0;
      mult_b       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      div_zero_exc <= 1'b0;
      div_start    <= 1'b0;
      mult_start   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      hi           <= hi_nxt;
      lo           <= lo_nxt;
      div_a        <= div_a_nxt;
      div_b        <= div_b_nxt;
      mult_a       <= mult_a_nxt;
      mult_b       <= mult_b_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      div_zero_exc <= div_zero_exc_nxt;
      div_start    <= div_start_nxt;
      mult_start   <= mult_start_nxt;
    end
  end

  // Next state and datapath; abort beats divzero, divzero beats the final capture
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hi_nxt     = hi;
    lo_nxt     = lo;
    div_a_nxt  = div_a;
    div_b_nxt  = div_b;
    mult_a_nxt = mult_a;
    mult_b_nxt = mult_b;
    case (state)
      S_IDLE: begin
        if (op_valid && !abort) begin
          case (op)
            OP_DIV: begin
              div_a_nxt = op_a;
              div_b_nxt = op_b;
              cnt_nxt   = CNT_W'(DIV_LAT);
              state_nxt = S_RUN_DIV;
            end
            OP_MULT: begin
              mult_a_nxt = op_a;
              mult_b_nxt = op_b;
              cnt_nxt    = CNT_W'(MULT_LAT);
              state_nxt  = S_RUN_MULT;
            end
            OP_MTHI: begin
              hi_nxt    = op_a;
              state_nxt = S_DONE;
            end
            OP_MTLO: begin
              lo_nxt    = op_a;
              state_nxt = S_DONE;
            end
            default: ;
          endcase
        end
      end
      S_RUN_DIV: begin
        if (abort) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else if (div_divzero) begin
          cnt_nxt   = '0;
          state_nxt = S_DZERO;
        end else if (cnt == '0) begin
          hi_nxt    = div_hi;
          lo_nxt    = div_lo;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_RUN_MULT: begin
        if (abort) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else if (cnt == '0) begin
          hi_nxt    = mult_hi;
          lo_nxt    = mult_lo;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_DZERO: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered
  always_comb begin
    busy_nxt         = (state_nxt != S_IDLE);
    done_nxt         = (state_nxt == S_DONE);
    div_zero_exc_nxt = (state_nxt == S_DZERO);
    div_start_nxt    = (state == S_IDLE) && (state_nxt == S_RUN_DIV);
    mult_start_nxt   = (state == S_IDLE) && (state_nxt == S_RUN_MULT);
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl with behavioural divider/multiplier models
// and transaction-level expectations for HI/LO and completion timing.
module tb_muldiv_ctrl;

  localparam int DLAT = 32;
  localparam int MLAT = 20;
  localparam logic [2:0] OP_MULT = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_MTHI = 3'b010;
  localparam logic [2:0] OP_MTLO = 3'b011;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, abort;
  logic [2:0]  op;
  logic [31:0] op_a, op_b;
  logic        busy, done, div_zero_exc, div_start, mult_start;
  logic [31:0] hi, lo, div_a, div_b, mult_a, mult_b;
  logic [31:0] div_hi, div_lo, mult_hi, mult_lo;
  logic        div_divzero;

  int n_cmp = 0;
  int n_fail = 0;

  // unit model state
  int          d_age = -1;
  int          m_age = -1;
  logic [31:0] ua, ub, ma, mb;

  // expected architectural registers
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  // per-transaction observations
  int da, za, nds, nms, nd, nz, ia;

  muldiv_ctrl #(.DIV_LAT(DLAT), .MULT_LAT(MLAT)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .op_a(op_a), .op_b(op_b),
    .abort(abort), .busy(busy), .done(done), .div_zero_exc(div_zero_exc), .hi(hi), .lo(lo),
    .div_start(div_start), .mult_start(mult_start), .div_a(div_a), .div_b(div_b),
    .mult_a(mult_a), .mult_b(mult_b), .div_hi(div_hi), .div_lo(div_lo),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .div_divzero(div_divzero)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; the units see their start pulse and answer exactly LAT cycles later
  task automatic step();
    logic [63:0] p;
    @(negedge clk);
    if (div_start) begin d_age = 0; ua = div_a; ub = div_b; end
    else if (d_age >= 0) d_age++;
    if (mult_start) begin m_age = 0; ma = mult_a; mb = mult_b; end
    else if (m_age >= 0) m_age++;
    div_divzero = (d_age == 1) && (ub == 32'd0);
    if (d_age == DLAT && ub != 32'd0) begin div_hi = ua % ub; div_lo = ua / ub; end
    else begin div_hi = $urandom; div_lo = $urandom; end
    p = 64'(ma) * 64'(mb);
    if (m_age == MLAT) begin mult_hi = p[63:32]; mult_lo = p[31:0]; end
    else begin mult_hi = $urandom; mult_lo = $urandom; end
  endtask

  // Issue one op in the current cycle and observe for max_cycles cycles
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int abort_at, input int extra_at, input int max_cycles);
    da = -1; za = -1; nds = 0; nms = 0; nd = 0; nz = 0; ia = -1;
    op_valid = 1'b1; op = o; op_a = a; op_b = b; abort = (abort_at == 0);
    for (int i = 1; i <= max_cycles; i++) begin
      step();
      if (done) begin nd++; if (da < 0) da = i; end
      if (div_zero_exc) begin nz++; if (za < 0) za = i; end
      if (div_start) nds++;
      if (mult_start) nms++;
      if (!busy && ia < 0) ia = i;
      op_valid = (i == extra_at);
      if (i == extra_at) begin op = OP_DIV; op_a = $urandom; op_b = $urandom_range(1, 1000); end
      abort = (i == abort_at);
    end
    op_valid = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if ({done, div_zero_exc, div_start, mult_start} !== 4'b0000) begin n_fail++; $display("FAIL reset_pulses got=%b exp=0000", {done, div_zero_exc, div_start, mult_start}); end
    n_cmp++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
    n_cmp++; if ({div_a, div_b, mult_a, mult_b} !== 128'd0) begin n_fail++; $display("FAIL reset_operands got=%h exp=0", {div_a, div_b, mult_a, mult_b}); end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_div_basic();
    run_op(OP_DIV, 32'd100, 32'd7, -1, -1, DLAT + 6);
    exp_hi = 32'd2; exp_lo = 32'd14;
    n_cmp++; if (nds !== 1) begin n_fail++; $display("FAIL div_start_count got=%0d exp=1", nds); end
    n_cmp++; if (da !== DLAT + 2) begin n_fail++; $display("FAIL div_done_at got=%0d exp=%0d", da, DLAT + 2); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL div_done_count got=%0d exp=1", nd); end
    n_cmp++; if (ia !== DLAT + 3) begin n_fail++; $display("FAIL div_busy_span got=%0d exp=%0d", ia, DLAT + 3); end
    n_cmp++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_fail++; $display("FAIL div_result got=%h/%h exp=%h/%h", hi, lo, exp_hi, exp_lo); end
  endtask

  task automatic test_mult();
    logic [31:0] a, b;
    logic [63:0] p;
    a = $urandom; b = $urandom;
    p = 64'(a) * 64'(b);
    run_op(OP_MULT, a, b, -1, -1, MLAT + 6);
    exp_hi = p[63:32]; exp_lo = p[31:0];
    n_cmp++; if (nms !== 1 || nds !== 0) begin n_fail++; $display("FAIL mult_starts got=%0d/%0d exp=1/0", nms, nds); end
    n_cmp++; if (da !== MLAT + 2) begin n_fail++; $display("FAIL mult_done_at got=%0d exp=%0d", da, MLAT + 2); end
    n_cmp++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_fail++; $display("FAIL mult_result got=%h/%h exp=%h/%h", hi, lo, exp_hi, exp_lo); end
  endtask

  task automatic test_div_zero();
    run_op(OP_MTHI, 32'h0000_1234, $urandom, -1, -1, 4);
    exp_hi = 32'h0000_1234;
    n_cmp++; if (da !== 1 || ia !== 2) begin n_fail++; $display("FAIL mthi_timing got=%0d/%0d exp=1/2", da, ia); end
    run_op(OP_MTLO, 32'h0000_5678, $urandom, -1, -1, 4);
    exp_lo = 32'h0000_5678;
    n_cmp++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_fail++; $display("FAIL mt_write got=%h/%h exp=%h/%h", hi, lo, exp_hi, exp_lo); end
    run_op(OP_DIV, $urandom, 32'd0, -1, -1, DLAT + 6);
    n_cmp++; if (za !== 3 || nz !== 1) begin n_fail++; $display("FAIL dz_pulse got=%0d/%0d exp=3/1", za, nz); end
    n_cmp++; if (nd !== 0) begin n_fail++; $display("FAIL dz_no_done got=%0d exp=0", nd); end
    n_cmp++; if (ia !== 4) begin n_fail++; $display("FAIL dz_idle_at got=%0d exp=4", ia); end
    n_cmp++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_fail++; $display("FAIL dz_hilo got=%h/%h exp=%h/%h", hi, lo, exp_hi, exp_lo); end
  endtask

  task automatic test_abort();
    run_op(OP_MULT, $urandom, $urandom, 10, -1, MLAT + 6);
    n_cmp++; if (ia !== 11) begin n_fail++; $display("FAIL abort_idle_at got=%0d exp=11", ia); end
    n_cmp++; if (nd !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", nd); end
    n_cmp++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_fail++; $display("FAIL abort_hilo got=%h/%h exp=%h/%h", hi, lo, exp_hi, exp_lo); end
    // abort coinciding with divzero
    run_op(OP_DIV, $urandom, 32'd0, 2, -1, 8);
    n_cmp++; if (nz !== 0 || ia !== 3) begin n_fail++; $display("FAIL abort_over_dz got=%0d/%0d exp=0/3", nz, ia); end
    // abort coinciding with the capture cycle
    run_op(OP_DIV, $urandom, 32'd5, DLAT + 1, -1, DLAT + 6);
    n_cmp++; if (nd !== 0 || ia !== DLAT + 2) begin n_fail++; $display("FAIL abort_over_cap got=%0d/%0d exp=0/%0d", nd, ia, DLAT + 2); end
    n_cmp++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_fail++; $display("FAIL abort_cap_hilo got=%h/%h exp=%h/%h", hi, lo, exp_hi, exp_lo); end
    // abort in IDLE drops the request
    run_op(OP_MULT, $urandom, $urandom, 0, -1, 4);
    n_cmp++; if (nms !== 0 || ia !== 1) begin n_fail++; $display("FAIL abort_idle_drop got=%0d/%0d exp=0/1", nms, ia); end
    // abort in DZERO and DONE has no effect
    run_op(OP_DIV, $urandom, 32'd0, 3, -1, 8);
    n_cmp++; if (nz !== 1 || ia !== 4) begin n_fail++; $display("FAIL abort_in_dz got=%0d/%0d exp=1/4", nz, ia); end
    run_op(OP_MTHI, 32'h0BAD_0BAD, $urandom, 1, -1, 4);
    exp_hi = 32'h0BAD_0BAD;
    n_cmp++; if (nd !== 1 || hi !== exp_hi) begin n_fail++; $display("FAIL abort_in_done got=%0d/%h exp=1/%h", nd, hi, exp_hi); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    a = $urandom; b = $urandom_range(1, 65535);
    run_op(OP_DIV, a, b, -1, 5, DLAT + 8);
    exp_hi = a % b; exp_lo = a / b;
    n_cmp++; if (nds !== 1 || nd !== 1) begin n_fail++; $display("FAIL b2b_counts got=%0d/%0d exp=1/1", nds, nd); end
    n_cmp++; if (da !== DLAT + 2) begin n_fail++; $display("FAIL b2b_done_at got=%0d exp=%0d", da, DLAT + 2); end
    n_cmp++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_fail++; $display("FAIL b2b_result got=%h/%h exp=%h/%h", hi, lo, exp_hi, exp_lo); end
  endtask

  task automatic test_mt_reserved();
    int dones = 0;
    run_op(OP_MTHI, 32'hDEAD_BEEF, $urandom, -1, -1, 3);
    dones += nd;
    run_op(OP_MTLO, 32'hCAFE_F00D, $urandom, -1, -1, 3);
    dones += nd;
    exp_hi = 32'hDEAD_BEEF; exp_lo = 32'hCAFE_F00D;
    n_cmp++; if (dones !== 2) begin n_fail++; $display("FAIL mt_done_count got=%0d exp=2", dones); end
    for (int r = 4; r < 8; r++) begin
      run_op(3'(r), $urandom, $urandom, -1, -1, 4);
      n_cmp++; if (ia !== 1 || nd !== 0 || nds + nms !== 0) begin n_fail++; $display("FAIL reserved_op%0d idle=%0d done=%0d starts=%0d exp=1/0/0", r, ia, nd, nds + nms); end
    end
    n_cmp++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_fail++; $display("FAIL mt_hilo got=%h/%h exp=%h/%h", hi, lo, exp_hi, exp_lo); end
  endtask

  task automatic test_reset_mid_run();
    int dones = 0;
    op_valid = 1'b1; op = OP_DIV; op_a = 32'd1000; op_b = 32'd3;
    step();
    op_valid = 1'b0;
    repeat (9) step();
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin n_fail++; $display("FAIL async_reset got=%b/%h exp=0/0", busy, {hi, lo}); end
    @(negedge clk);
    reset = 1'b1;
    exp_hi = '0; exp_lo = '0;
    for (int i = 0; i < DLAT + 6; i++) begin step(); if (done) dones++; end
    n_cmp++; if (dones !== 0 || {hi, lo} !== 64'd0) begin n_fail++; $display("FAIL reset_late_result done=%0d hilo=%h exp=0/0", dones, {hi, lo}); end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [63:0] p;
    for (int k = 0; k < 10; k++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_op(o, a, b, -1, -1, ((o == OP_MULT) ? MLAT : DLAT) + 4);
      case (o)
        OP_MULT: begin
          p = 64'(a) * 64'(b);
          exp_hi = p[63:32]; exp_lo = p[31:0];
          n_cmp++; if (da !== MLAT + 2) begin n_fail++; $display("FAIL rnd%0d_mult_done got=%0d exp=%0d", k, da, MLAT + 2); end
        end
        OP_DIV: begin
          if (b == 32'd0) begin
            n_cmp++; if (za !== 3 || nd !== 0) begin n_fail++; $display("FAIL rnd%0d_dz got=%0d/%0d exp=3/0", k, za, nd); end
          end else begin
            exp_hi = a % b; exp_lo = a / b;
            n_cmp++; if (da !== DLAT + 2) begin n_fail++; $display("FAIL rnd%0d_div_done got=%0d exp=%0d", k, da, DLAT + 2); end
          end
        end
        OP_MTHI: begin
          exp_hi = a;
          n_cmp++; if (da !== 1) begin n_fail++; $display("FAIL rnd%0d_mthi_done got=%0d exp=1", k, da); end
        end
        default: begin
          exp_lo = a;
          n_cmp++; if (da !== 1) begin n_fail++; $display("FAIL rnd%0d_mtlo_done got=%0d exp=1", k, da); end
        end
      endcase
      n_cmp++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_fail++; $display("FAIL rnd%0d_hilo op=%0d got=%h/%h exp=%h/%h", k, o, hi, lo, exp_hi, exp_lo); end
    end
  endtask

  initial begin
    op_valid = 1'b0; abort = 1'b0; op = '0; op_a = '0; op_b = '0;
    div_hi = '0; div_lo = '0; mult_hi = '0; mult_lo = '0; div_divzero = 1'b0;
    ua = '0; ub = '0; ma = '0; mb = '0;
    test_reset();
    test_div_basic();
    test_mult();
    test_div_zero();
    test_abort();
    test_back_to_back();
    test_mt_reserved();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
